// File: rtl/dino_vga_renderer_pkg.sv
// Shared constants, types and sprite artwork for the dino VGA renderer.
package dino_vga_renderer_pkg;

    // Pixel format
    localparam int COLOR_W = 4;
    localparam int RGB_W   = 3 * COLOR_W;

    // Counter / coordinate widths (coordinates are signed so boxes clip at x=0)
    localparam int CNT_W = 11;
    localparam int CRD_W = 13;

    // VGA porch and sync widths (active sizes are top-level parameters)
    localparam int H_FRONT_PORCH = 16;
    localparam int H_SYNC_WIDTH  = 96;
    localparam int H_BACK_PORCH  = 48;
    localparam int V_FRONT_PORCH = 10;
    localparam int V_SYNC_WIDTH  = 2;
    localparam int V_BACK_PORCH  = 33;

    // Scene placement
    localparam int DINO_SCREEN_X   = 48;
    localparam int GROUND_SCREEN_Y = 8;

    // Sprite geometry
    localparam int DINO_BITMAP_SIZE_X       = 32;
    localparam int DINO_BITMAP_SIZE_Y       = 32;
    localparam int DINO_BITMAP_CENTER_X     = 16;
    localparam int DINO_BITMAP_CENTER_Y     = 16;
    localparam int OBSTACLE_BITMAP_SIZE_X   = 16;
    localparam int OBSTACLE_BITMAP_SIZE_Y   = 32;
    localparam int OBSTACLE_BITMAP_CENTER_X = 8;
    localparam int OBSTACLE_BITMAP_CENTER_Y = 16;

    localparam int DINO_ROW_W = $clog2(DINO_BITMAP_SIZE_Y);
    localparam int DINO_COL_W = $clog2(DINO_BITMAP_SIZE_X);
    localparam int OBS_ROW_W  = $clog2(OBSTACLE_BITMAP_SIZE_Y);
    localparam int OBS_COL_W  = $clog2(OBSTACLE_BITMAP_SIZE_X);

    // Animation frame codes; the code doubles as the dino ROM page
    typedef enum logic [1:0] {
        DINO_RUNNING_1 = 2'd0,
        DINO_RUNNING_2 = 2'd1,
        DINO_JUMPING   = 2'd2,
        DINO_DEAD      = 2'd3
    } dino_state_e;

    // Colours {R,G,B}
    localparam logic [RGB_W-1:0] COLOR_FG      = 12'h555;
    localparam logic [RGB_W-1:0] COLOR_BG      = 12'hFFF;
    localparam logic [RGB_W-1:0] COLOR_BG_OVER = 12'hFCC;

    // Per-pixel control carried alongside the ROM read
    typedef struct packed {
        logic active;
        logic hsync;
        logic vsync;
        logic in_dino;
        logic in_obstacle;
        logic ground;
        logic game_over;
    } pix_ctl_t;

    localparam pix_ctl_t PIX_CTL_RESET = '{active: 1'b0, hsync: 1'b1, vsync: 1'b1,
                                           in_dino: 1'b0, in_obstacle: 1'b0,
                                           ground: 1'b0, game_over: 1'b0};

    // Dino artwork: diagonal stripe pattern, shifted per page so frames differ
    function automatic logic dino_rom_bit(input logic [1:0]            page,
                                          input logic [DINO_ROW_W-1:0] row,
                                          input logic [DINO_COL_W-1:0] col);
        logic [6:0] s;
        s = 7'(row) + 7'(col) + 7'(page);
        return (s % 7'd3) != 7'd0;
    endfunction

    // Obstacle artwork: steeper stripe pattern
    function automatic logic obstacle_rom_bit(input logic [OBS_ROW_W-1:0] row,
                                              input logic [OBS_COL_W-1:0] col);
        logic [6:0] s;
        s = 7'(row) + {2'b00, col, 1'b0};
        return (s % 7'd5) != 7'd0;
    endfunction

endpackage

// File: rtl/dino_vga_renderer_sprite_rom.sv
// Sprite ROM: 4 dino pages of 32x32 and one 16x32 obstacle, 1-cycle read.
module dino_vga_renderer_sprite_rom
    import dino_vga_renderer_pkg::*;
(
    input  logic                  vga_clk,
    input  logic                  rst_n,
    input  logic [1:0]            dino_page,
    input  logic [DINO_ROW_W-1:0] dino_row,
    input  logic [DINO_COL_W-1:0] dino_col,
    input  logic [OBS_ROW_W-1:0]  obstacle_row,
    input  logic [OBS_COL_W-1:0]  obstacle_col,
    output logic                  dino_bit,
    output logic                  obstacle_bit
);

    // Registered lookup; clears with the rest of the pixel pipeline
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            dino_bit     <= 1'b0;
            obstacle_bit <= 1'b0;
        end else begin
            dino_bit     <= dino_rom_bit(dino_page, dino_row, dino_col);
            obstacle_bit <= obstacle_rom_bit(obstacle_row, obstacle_col);
        end
    end

endmodule

// File: rtl/dino_vga_renderer.sv
// VGA renderer: timing counters, per-frame state snapshot, sprite compositing.
// Latency from counter value to hsync/vsync/rgb is two cycles.
module dino_vga_renderer
    import dino_vga_renderer_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic             vga_clk,
    input  logic             rst_n,
    input  logic [11:0]      dino_y,
    input  logic [11:0]      obstacle_x,
    input  logic [1:0]       dino_state,
    input  logic             game_over,
    output logic             hsync,
    output logic             vsync,
    output logic [RGB_W-1:0] rgb,
    output logic             frame_tick
);

    localparam int H_TOTAL      = H_ACTIVE + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH;
    localparam int V_TOTAL      = V_ACTIVE + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH;
    localparam int H_SYNC_START = H_ACTIVE + H_FRONT_PORCH;
    localparam int V_SYNC_START = V_ACTIVE + V_FRONT_PORCH;

    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_C = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_SYNC_START);
    localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_SYNC_START + H_SYNC_WIDTH);
    localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_SYNC_START);
    localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_SYNC_START + V_SYNC_WIDTH);

    localparam logic signed [CRD_W-1:0] WY_TOP      = CRD_W'(V_ACTIVE - 1);
    localparam logic signed [CRD_W-1:0] DINO_LEFT   = CRD_W'(DINO_SCREEN_X - DINO_BITMAP_CENTER_X);
    localparam logic signed [CRD_W-1:0] DINO_W_S    = CRD_W'(DINO_BITMAP_SIZE_X);
    localparam logic signed [CRD_W-1:0] DINO_H_S    = CRD_W'(DINO_BITMAP_SIZE_Y);
    localparam logic signed [CRD_W-1:0] OBS_CX_S    = CRD_W'(OBSTACLE_BITMAP_CENTER_X);
    localparam logic signed [CRD_W-1:0] OBS_W_S     = CRD_W'(OBSTACLE_BITMAP_SIZE_X);
    localparam logic signed [CRD_W-1:0] OBS_H_S     = CRD_W'(OBSTACLE_BITMAP_SIZE_Y);
    localparam logic signed [CRD_W-1:0] GROUND_S    = CRD_W'(GROUND_SCREEN_Y);
    localparam logic signed [CRD_W-1:0] GROUND_LN_S = CRD_W'(GROUND_SCREEN_Y - 1);

    localparam logic [DINO_ROW_W-1:0] DINO_LAST_ROW = DINO_ROW_W'(DINO_BITMAP_SIZE_Y - 1);
    localparam logic [OBS_ROW_W-1:0]  OBS_LAST_ROW  = OBS_ROW_W'(OBSTACLE_BITMAP_SIZE_Y - 1);

    // S0: raster position
    logic [CNT_W-1:0] h_cnt, v_cnt;

    // Frame-stable copies of the game state
    logic [11:0] sh_dino_y, sh_obstacle_x;
    logic [1:0]  sh_dino_state;
    logic        sh_game_over;

    // S0 geometry (signed; differences keep off-screen boxes from wrapping)
    logic signed [CRD_W-1:0] px, wy, dino_dx, dino_dy, obs_left, obs_dx, obs_dy;

    pix_ctl_t                s0_ctl, s1_ctl;
    logic [1:0]              dino_page;
    logic [DINO_ROW_W-1:0]   dino_row;
    logic [DINO_COL_W-1:0]   dino_col;
    logic [OBS_ROW_W-1:0]    obstacle_row;
    logic [OBS_COL_W-1:0]    obstacle_col;
    logic                    dino_bit, obstacle_bit, fg;

    // Raster counters: h wraps at end of line and advances v
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    assign frame_tick = (h_cnt == '0) && (v_cnt == V_ACT_C);

    // Snapshot game state once per frame, at the start of vertical blank
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_dino_y     <= 12'(GROUND_SCREEN_Y);
            sh_obstacle_x <= '0;
            sh_dino_state <= DINO_RUNNING_1;
            sh_game_over  <= 1'b0;
        end else if (frame_tick) begin
            sh_dino_y     <= dino_y;
            sh_obstacle_x <= obstacle_x;
            sh_dino_state <= dino_state;
            sh_game_over  <= game_over;
        end
    end

    // S0: sync/active decode, box tests and ROM addressing
    always_comb begin
        px       = CRD_W'(h_cnt);
        wy       = WY_TOP - CRD_W'(v_cnt);
        dino_dx  = px - DINO_LEFT;
        dino_dy  = wy - CRD_W'(sh_dino_y);
        obs_left = CRD_W'(sh_obstacle_x) - OBS_CX_S;
        obs_dx   = px - obs_left;
        obs_dy   = wy - GROUND_S;

        s0_ctl             = PIX_CTL_RESET;
        s0_ctl.active      = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
        s0_ctl.hsync       = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
        s0_ctl.vsync       = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
        s0_ctl.in_dino     = !dino_dx[CRD_W-1] && (dino_dx < DINO_W_S) &&
                             !dino_dy[CRD_W-1] && (dino_dy < DINO_H_S);
        s0_ctl.in_obstacle = !obs_dx[CRD_W-1] && (obs_dx < OBS_W_S) &&
                             !obs_dy[CRD_W-1] && (obs_dy < OBS_H_S);
        s0_ctl.ground      = (wy == GROUND_LN_S);
        s0_ctl.game_over   = sh_game_over;

        // Bitmap row 0 is the top of the sprite, world y grows upward
        dino_page    = sh_game_over ? 2'(DINO_DEAD) : sh_dino_state;
        dino_col     = dino_dx[DINO_COL_W-1:0];
        dino_row     = DINO_LAST_ROW - dino_dy[DINO_ROW_W-1:0];
        obstacle_col = obs_dx[OBS_COL_W-1:0];
        obstacle_row = OBS_LAST_ROW - obs_dy[OBS_ROW_W-1:0];
    end

    // S1: ROM read; registered alongside the control word below
    dino_vga_renderer_sprite_rom sprite_rom (
        .vga_clk      (vga_clk),
        .rst_n        (rst_n),
        .dino_page    (dino_page),
        .dino_row     (dino_row),
        .dino_col     (dino_col),
        .obstacle_row (obstacle_row),
        .obstacle_col (obstacle_col),
        .dino_bit     (dino_bit),
        .obstacle_bit (obstacle_bit)
    );

    // S1: carry the S0 decode in step with the ROM data
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) s1_ctl <= PIX_CTL_RESET;
        else        s1_ctl <= s0_ctl;
    end

    // Priority: dino > obstacle > ground line > background
    always_comb begin
        fg = 1'b0;
        if (s1_ctl.in_dino && dino_bit)              fg = 1'b1;
        else if (s1_ctl.in_obstacle && obstacle_bit) fg = 1'b1;
        else if (s1_ctl.ground)                      fg = 1'b1;
    end

    // S2: colour select and blanking, registered to the pins
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync <= 1'b1;
            vsync <= 1'b1;
            rgb   <= '0;
        end else begin
            hsync <= s1_ctl.hsync;
            vsync <= s1_ctl.vsync;
            if (!s1_ctl.active)       rgb <= '0;
            else if (fg)              rgb <= COLOR_FG;
            else if (s1_ctl.game_over) rgb <= COLOR_BG_OVER;
            else                      rgb <= COLOR_BG;
        end
    end

endmodule

// File: tb/tb_dino_vga_renderer.sv
// Randomized scoreboard bench for dino_vga_renderer on a reduced raster.
module tb_dino_vga_renderer;
    import dino_vga_renderer_pkg::*;

    localparam int HA    = 80;
    localparam int VA    = 48;
    localparam int HT    = HA + 160;
    localparam int VT    = VA + 45;
    localparam int FRAME = HT * VT;
    localparam int TICK0 = VA * HT;

    logic        vga_clk = 1'b0;
    logic        rst_n;
    logic [11:0] dino_y, obstacle_x;
    logic [1:0]  dino_state;
    logic        game_over;
    logic        hsync, vsync, frame_tick;
    logic [11:0] rgb;

    dino_vga_renderer #(.H_ACTIVE(HA), .V_ACTIVE(VA)) dut (
        .vga_clk    (vga_clk),
        .rst_n      (rst_n),
        .dino_y     (dino_y),
        .obstacle_x (obstacle_x),
        .dino_state (dino_state),
        .game_over  (game_over),
        .hsync      (hsync),
        .vsync      (vsync),
        .rgb        (rgb),
        .frame_tick (frame_tick)
    );

    always #20 vga_clk = ~vga_clk;

    typedef struct {
        int          cyc;
        bit          hs;
        bit          vs;
        logic [11:0] rgb;
    } pix_exp_t;

    pix_exp_t pq[$];
    bit       tq[$];
    int       n_checks = 0;
    int       n_fail   = 0;

    // Reference state: cycles since reset release and the frame snapshot
    int mcyc, m_dy, m_ox, m_st;
    bit m_go;

    // Expected pins for the raster position reached c cycles after release
    function automatic pix_exp_t model_pixel(int c, int dy, int ox, int st, bit go);
        pix_exp_t e;
        int h, v, wy, dx0, ox0, page;
        bit fg;
        h     = c % HT;
        v     = (c / HT) % VT;
        e.cyc = c;
        e.hs  = !(h >= HA + 16 && h < HA + 112);
        e.vs  = !(v >= VA + 10 && v < VA + 12);
        e.rgb = 12'h000;
        if (h < HA && v < VA) begin
            wy   = VA - 1 - v;
            dx0  = DINO_SCREEN_X - DINO_BITMAP_CENTER_X;
            ox0  = ox - OBSTACLE_BITMAP_CENTER_X;
            page = go ? 3 : st;
            fg   = 1'b0;
            if (h >= dx0 && h < dx0 + DINO_BITMAP_SIZE_X &&
                wy >= dy && wy < dy + DINO_BITMAP_SIZE_Y &&
                dino_rom_bit(2'(page), 5'(dy + DINO_BITMAP_SIZE_Y - 1 - wy), 5'(h - dx0)))
                fg = 1'b1;
            else if (h >= ox0 && h < ox0 + OBSTACLE_BITMAP_SIZE_X &&
                     wy >= GROUND_SCREEN_Y && wy < GROUND_SCREEN_Y + OBSTACLE_BITMAP_SIZE_Y &&
                     obstacle_rom_bit(5'(GROUND_SCREEN_Y + OBSTACLE_BITMAP_SIZE_Y - 1 - wy),
                                      4'(h - ox0)))
                fg = 1'b1;
            else if (wy == GROUND_SCREEN_Y - 1)
                fg = 1'b1;
            e.rgb = fg ? 12'h555 : (go ? 12'hFCC : 12'hFFF);
        end
        return e;
    endfunction

    task automatic check(input string name, input int cyc, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    // Reference model: predicts each cycle's pins and the frame tick
    always @(negedge vga_clk) begin
        if (!rst_n) begin
            mcyc = 0;
            pq.delete();
            tq.delete();
            m_dy = GROUND_SCREEN_Y;
            m_ox = 0;
            m_st = 0;
            m_go = 1'b0;
        end else begin
            bit tick;
            pq.push_back(model_pixel(mcyc, m_dy, m_ox, m_st, m_go));
            tick = (mcyc >= TICK0) && (((mcyc - TICK0) % FRAME) == 0);
            tq.push_back(tick);
            if (tick) begin
                m_dy = int'(dino_y);
                m_ox = int'(obstacle_x);
                m_st = int'(dino_state);
                m_go = game_over;
            end
            mcyc++;
        end
    end

    // Monitor: tick has no latency, pixel pins lag the raster by two cycles
    always @(negedge vga_clk) begin
        #1;
        if (!rst_n) begin
            check("rst_hsync", -1, 32'(hsync), 32'd1);
            check("rst_vsync", -1, 32'(vsync), 32'd1);
            check("rst_rgb",   -1, 32'(rgb),   32'd0);
            check("rst_tick",  -1, 32'(frame_tick), 32'd0);
        end else begin
            if (tq.size() > 0) begin
                bit t;
                t = tq.pop_front();
                check("frame_tick", mcyc - 1, 32'(frame_tick), 32'(t));
            end
            if (pq.size() >= 3) begin
                pix_exp_t e;
                e = pq.pop_front();
                check("hsync", e.cyc, 32'(hsync), 32'(e.hs));
                check("vsync", e.cyc, 32'(vsync), 32'(e.vs));
                check("rgb",   e.cyc, 32'(rgb),   32'(e.rgb));
            end
        end
    end

    task automatic drive_random();
        dino_y     = 12'($urandom_range(0, 4095));
        obstacle_x = 12'($urandom_range(0, 4095));
        dino_state = 2'($urandom_range(0, 3));
        game_over  = 1'($urandom_range(0, 1));
    endtask

    task automatic run_cycles(input int n, input bit rnd);
        repeat (n) begin
            @(posedge vga_clk);
            #1;
            if (rnd) drive_random();
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        dino_y     = '0;
        obstacle_x = '0;
        dino_state = '0;
        game_over  = 1'b0;
        repeat (3) @(posedge vga_clk);
        #2 rst_n = 1'b1;

        // Reset shadows render (obstacle_x=0 clipped at left edge); then
        // a mid-line reset at h=30, v=20
        run_cycles(20 * HT + 30, 1'b1);
        rst_n = 1'b0;
        repeat (5) @(posedge vga_clk);
        #2 rst_n = 1'b1;

        // Frame A: random scene, inputs churn freely while it is drawn
        run_cycles(TICK0 - 3, 1'b1);
        dino_y     = 12'($urandom_range(0, 12));
        obstacle_x = 12'($urandom_range(0, HA + 12));
        dino_state = 2'($urandom_range(0, 2));
        game_over  = 1'b0;
        run_cycles(5, 1'b0);
        run_cycles(FRAME - 5, 1'b1);

        // Frame B: game over with RUNNING_2, dino on ground, obstacle at x=3
        dino_y     = 12'(GROUND_SCREEN_Y);
        obstacle_x = 12'd3;
        dino_state = DINO_RUNNING_2;
        game_over  = 1'b1;
        run_cycles(5, 1'b0);
        run_cycles(FRAME, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
